uart_rx_frame_chk: RTL and testbench

UART_RX_FRAME_CHK -- requirements
Module: uart_rx_frame_chk

---
 rtl/uart_rx_frame_chk.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_frame_chk.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_chk.sv
// UART receiver with oversampled majority-vote bit recovery and frame checking.
// Frame: start bit, DATA_WIDTH data bits (LSB first), optional parity bit, one stop bit.
// Optional feature macro: UART_RX_PAR_CHK_EN enables the parity bit and parity check.
// Without it, frames are always start+data+stop, par_en/par_typ are ignored and par_err stays 0.
module uart_rx_frame_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP0     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP1     = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP2     = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PAR_CHK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state, state_n;
    logic                  rx_meta, rx_s;
    logic [CW-1:0]         cnt;
    logic [2:0]            samp;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  s2, maj, bit_end;
    logic                  dv_n, pe_n, se_n;

`ifdef UART_RX_PAR_CHK_EN
    logic                  par_en_q, par_typ_q, par_flag, exp_par;
    assign exp_par = par_typ_q ? ~^shift_reg : ^shift_reg;
`else
    logic                  unused_cfg;
    assign unused_cfg = par_en ^ par_typ;
`endif

    // The third vote may fall on the last count of the bit, so use the live sample then.
    assign s2      = (cnt == SMP2) ? rx_s : samp[2];
    assign maj     = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);
    assign bit_end = (cnt == CNT_LAST);
    assign busy    = (state != IDLE);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Next-state and end-of-frame pulse decisions.
    always_comb begin
        state_n = state;
        dv_n    = 1'b0;
        pe_n    = 1'b0;
        se_n    = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_n = START;
            START: if (bit_end) state_n = maj ? IDLE : DATA;
            DATA: begin
                if (bit_end && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PAR_CHK_EN
                    state_n = par_en_q ? PARITY : STOP;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PAR_CHK_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    se_n    = ~maj;
`ifdef UART_RX_PAR_CHK_EN
                    pe_n    = par_flag;
                    dv_n    = maj & ~par_flag;
`else
                    dv_n    = maj;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, registered result pulses and the held output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            p_data     <= '0;
        end else begin
            state      <= state_n;
            data_valid <= dv_n;
            par_err    <= pe_n;
            stp_err    <= se_n;
            if (dv_n) p_data <= shift_reg;
        end
    end

    // Bit timing, vote sampling, data shifting and per-frame configuration capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            samp      <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PAR_CHK_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_flag  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            cnt     <= rx_s ? '0 : CW'(1);
            bit_cnt <= '0;
`ifdef UART_RX_PAR_CHK_EN
            par_flag <= 1'b0;
            if (!rx_s) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
            end
`endif
        end else begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
            if (cnt == SMP0) samp[0] <= rx_s;
            if (cnt == SMP1) samp[1] <= rx_s;
            if (cnt == SMP2) samp[2] <= rx_s;
            if ((state == DATA) && bit_end) begin
                shift_reg <= {maj, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + BW'(1);
            end
`ifdef UART_RX_PAR_CHK_EN
            if ((state == PARITY) && bit_end && (maj != exp_par)) par_flag <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Directed testbench for uart_rx_frame_chk (DATA_WIDTH=8, OVERSAMPLE=8).
// Parity cases run when UART_RX_PAR_CHK_EN is defined; otherwise the no-parity build is checked.
module tb_uart_rx_frame_chk;

    localparam int OS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] pdata_at_err = '0;

    uart_rx_frame_chk #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count output pulses and remember when they occurred, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
        end
        if (par_err) begin
            pe_cnt = pe_cnt + 1;
            pe_cyc = cyc;
            pdata_at_err = p_data;
        end
        if (stp_err) begin
            se_cnt = se_cnt + 1;
            se_cyc = cyc;
            pdata_at_err = p_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveBit(input logic b);
        rx_in = b;
        repeat (OS) @(negedge clk);
    endtask

    // Drives one whole frame starting at the current negedge; d is the drive cycle.
    // rx_s sees the start bit two cycles later, which is frame cycle 0.
    task automatic applyStimulus(input logic [7:0] data, input bit has_par, input bit par_bit,
                                 input bit stop_bit, output int d);
        d = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        if (has_par) driveBit(par_bit);
        driveBit(stop_bit);
    endtask

    initial begin
        int d, d2, b_dv, b_pe, b_se;
        logic [7:0] exp_pdata;

        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_p_data", p_data, 0);
        checkOutput("rst_dv", data_valid, 0);
        checkOutput("rst_par_err", par_err, 0);
        checkOutput("rst_stp_err", stp_err, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_pdata = 8'h00;

`ifdef UART_RX_PAR_CHK_EN
        $display("[TB] good even-parity frame 0xA5");
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        par_en = 1'b1; par_typ = 1'b0;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, d);
        repeat (6) @(negedge clk);
        checkOutput("even_dv_cnt", dv_cnt - b_dv, 1);
        checkOutput("even_dv_cycle", dv_cyc - d, 90);
        checkOutput("even_p_data", p_data, 8'hA5);
        checkOutput("even_no_err", (pe_cnt - b_pe) + (se_cnt - b_se), 0);
        exp_pdata = 8'hA5;

        $display("[TB] odd parity mismatch on 0xA5, par_typ flipped mid-frame");
        b_dv = dv_cnt; b_pe = pe_cnt;
        par_typ = 1'b1;
        fork
            applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, d);
            begin
                repeat (20) @(negedge clk);
                par_typ = 1'b0;
            end
        join
        repeat (6) @(negedge clk);
        checkOutput("odd_pe_cnt", pe_cnt - b_pe, 1);
        checkOutput("odd_pe_cycle", pe_cyc - d, 90);
        checkOutput("odd_no_dv", dv_cnt - b_dv, 0);
        checkOutput("odd_p_data_held", p_data, exp_pdata);
`else
        $display("[TB] no-parity build, par_en=1 ignored, frame 0xF0");
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        par_en = 1'b1; par_typ = 1'b1;
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1, d);
        repeat (6) @(negedge clk);
        checkOutput("nopar_dv_cnt", dv_cnt - b_dv, 1);
        checkOutput("nopar_dv_cycle", dv_cyc - d, 82);
        checkOutput("nopar_p_data", p_data, 8'hF0);
        checkOutput("nopar_no_err", (pe_cnt - b_pe) + (se_cnt - b_se), 0);
        exp_pdata = 8'hF0;
`endif

        $display("[TB] stop error on 0x3C then back-to-back 0x81");
        b_dv = dv_cnt; b_se = se_cnt;
        par_en = 1'b0; par_typ = 1'b0;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, d);
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, d2);
        repeat (6) @(negedge clk);
        checkOutput("stp_se_cnt", se_cnt - b_se, 1);
        checkOutput("stp_se_cycle", se_cyc - d, 82);
        checkOutput("stp_p_data_held", pdata_at_err, exp_pdata);
        checkOutput("b2b_dv_cnt", dv_cnt - b_dv, 1);
        checkOutput("b2b_dv_cycle", dv_cyc - d2, 82);
        checkOutput("b2b_p_data", p_data, 8'h81);
        exp_pdata = 8'h81;

        $display("[TB] two-cycle glitch rejected");
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        d = cyc;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        checkOutput("glitch_busy_start", busy, 1);
        repeat (6) @(negedge clk);
        checkOutput("glitch_busy_last", busy, 1);
        @(negedge clk);
        checkOutput("glitch_busy_drop", busy, 0);
        repeat (20) @(negedge clk);
        checkOutput("glitch_no_pulse", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se), 0);

        $display("[TB] reset during data bit 4, then frame 0x55");
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_p_data", p_data, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_pulses", {29'd0, data_valid, par_err, stp_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_rst_no_pulse", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se), 0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, d);
        repeat (6) @(negedge clk);
        checkOutput("after_rst_dv_cnt", dv_cnt - b_dv, 1);
        checkOutput("after_rst_dv_cycle", dv_cyc - d, 82);
        checkOutput("after_rst_p_data", p_data, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
